// File: rtl/uart_pkg.sv
// Shared definitions for the host<->FPGA serial link: receiver states,
// command byte values and the default bit period for 100 MHz / 9600 baud.
package uart_pkg;

   localparam int unsigned CLKS_PER_BIT_DEFAULT = 10417;

   localparam logic [7:0] CMD_CAPTURE = 8'h43;
   localparam logic [7:0] CMD_NOP     = 8'h00;

   typedef enum logic [2:0] {
      WAIT_HIGH,
      IDLE,
      START,
      DATA,
      STOP
   } rx_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous inputs, with a selectable value
// loaded on reset so an idle line does not look active while reset is held.
module sync_2ff #(
   parameter int unsigned     WIDTH     = 1,
   parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta;

   // NOTE: sequential state uses <= so both stages sample the pre-edge values;
   // a blocking = here would collapse the chain into a single flop.
   always_ff @(posedge clk) begin
      if (rst) begin
         meta <= RESET_VAL;
         q    <= RESET_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/uart_cmd_rx.sv
// 8N1 UART receiver for host commands: presents each good byte with a strobe
// and pulses o_Frame_Request when the capture command byte arrives.
module uart_cmd_rx #(
   parameter int unsigned CLKS_PER_BIT = uart_pkg::CLKS_PER_BIT_DEFAULT,
   parameter logic [7:0]  CMD_CAPTURE  = uart_pkg::CMD_CAPTURE
) (
   input  logic       Clk,
   input  logic       Rst,
   input  logic       i_Rx,
   output logic [7:0] o_Data,
   output logic       o_Valid,
   output logic       o_Frame_Request,
   output logic       o_Frame_Err,
   output logic       o_Busy
);

   import uart_pkg::*;

   localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

   if (CLKS_PER_BIT < 8) begin : g_bad_clks_per_bit
      $error("uart_cmd_rx: CLKS_PER_BIT must be at least 8");
   end

   rx_state_t        state, state_next;
   logic [CNT_W-1:0] cnt, cnt_next;
   logic [2:0]       bit_idx, bit_idx_next;
   logic [7:0]       shift, shift_next;
   logic [7:0]       data_next;
   logic             valid_next;
   logic             frame_req_next;
   logic             frame_err_next;
   logic             rx_s;

   sync_2ff #(
      .WIDTH    (1),
      .RESET_VAL(1'b1)
   ) u_rx_sync (
      .clk(Clk),
      .rst(Rst),
      .d  (i_Rx),
      .q  (rx_s)
   );

   // NOTE: every signal written below gets a default first, so no path
   // through the case leaves one unassigned and no latch is inferred.
   always_comb begin
      state_next     = state;
      cnt_next       = cnt + 1'b1;
      bit_idx_next   = bit_idx;
      shift_next     = shift;
      data_next      = o_Data;
      valid_next     = 1'b0;
      frame_req_next = 1'b0;
      frame_err_next = 1'b0;

      case (state)
         WAIT_HIGH: begin
            cnt_next = '0;
            if (rx_s) state_next = IDLE;
         end
         IDLE: begin
            cnt_next = '0;
            if (!rx_s) state_next = START;
         end
         START: begin
            if (cnt == CNT_HALF) begin
               if (!rx_s) begin
                  state_next   = DATA;
                  bit_idx_next = 3'd0;
               end else begin
                  state_next = IDLE;
               end
            end
         end
         DATA: begin
            if (cnt == CNT_LAST) begin
               shift_next   = {rx_s, shift[7:1]};
               bit_idx_next = bit_idx + 3'd1;
               cnt_next     = '0;
               if (bit_idx == 3'd7) state_next = STOP;
            end
         end
         STOP: begin
            // Leaving at mid stop bit gives half a bit of margin for the next start edge.
            if (cnt == CNT_LAST) begin
               if (rx_s) begin
                  data_next      = shift;
                  valid_next     = 1'b1;
                  frame_req_next = (shift == CMD_CAPTURE);
                  state_next     = IDLE;
               end else begin
                  frame_err_next = 1'b1;
                  state_next     = WAIT_HIGH;
               end
            end
         end
         default: state_next = WAIT_HIGH;
      endcase

      if (state_next != state) cnt_next = '0;
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state           <= WAIT_HIGH;
         cnt             <= '0;
         bit_idx         <= 3'd0;
         shift           <= 8'h00;
         o_Data          <= 8'h00;
         o_Valid         <= 1'b0;
         o_Frame_Request <= 1'b0;
         o_Frame_Err     <= 1'b0;
      end else begin
         state           <= state_next;
         cnt             <= cnt_next;
         bit_idx         <= bit_idx_next;
         shift           <= shift_next;
         o_Data          <= data_next;
         o_Valid         <= valid_next;
         o_Frame_Request <= frame_req_next;
         o_Frame_Err     <= frame_err_next;
      end
   end

   assign o_Busy = (state != IDLE);

endmodule
